// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: five-state FETCH/DECODE/EXEC/MEM/WB sequencer
// driving datapath write enables, mux selects and a req/ack memory port.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [1:0] alu_op,
  output logic       alu_bsel,
  output logic       ext_op,
  output logic [2:0] state,
  output logic       illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic rtype, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, supported;

  assign rtype     = (op == 6'b000000);
  assign is_addu   = rtype && (funct == 6'b100001);
  assign is_subu   = rtype && (funct == 6'b100011);
  assign is_jr     = rtype && (funct == 6'b001000);
  assign is_nop    = rtype && (funct == 6'b000000);
  assign is_ori    = (op == 6'b001101);
  assign is_lui    = (op == 6'b001111);
  assign is_lw     = (op == 6'b100011);
  assign is_sw     = (op == 6'b101011);
  assign is_beq    = (op == 6'b000100);
  assign is_j      = (op == 6'b000010);
  assign is_jal    = (op == 6'b000011);
  assign supported = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui |
                     is_lw | is_sw | is_beq | is_j | is_jal;

  logic [2:0] next_state;
  logic       req_c, we_c, ir_c, pc_c, reg_c;

  always_comb begin
    next_state = S_FETCH;
    req_c      = 1'b0;
    we_c       = 1'b0;
    ir_c       = 1'b0;
    pc_c       = 1'b0;
    reg_c      = 1'b0;
    mem_src    = 1'b0;
    pc_sel     = 2'b00;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    alu_op     = 2'b00;
    alu_bsel   = 1'b0;
    ext_op     = 1'b0;
    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          ir_c       = 1'b1;
          pc_c       = 1'b1;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        // Jumps finish here; nop and illegal words fall straight back to fetch
        if (is_j || is_jal) begin
          pc_c   = 1'b1;
          pc_sel = 2'b10;
          if (is_jal) begin
            reg_c   = 1'b1;
            reg_dst = 2'b10;
            wd_sel  = 2'b10;
          end
        end else if (is_jr) begin
          pc_c   = 1'b1;
          pc_sel = 2'b11;
        end else if (supported && !is_nop) begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_addu || is_subu) begin
          alu_op     = is_subu ? 2'b01 : 2'b00;
          next_state = S_WB;
        end else if (is_ori) begin
          alu_op     = 2'b10;
          alu_bsel   = 1'b1;
          next_state = S_WB;
        end else if (is_lui) begin
          alu_op     = 2'b11;
          alu_bsel   = 1'b1;
          next_state = S_WB;
        end else if (is_lw || is_sw) begin
          alu_bsel   = 1'b1;
          ext_op     = 1'b1;
          next_state = S_MEM;
        end else if (is_beq) begin
          alu_op = 2'b01;
          if (zero) begin
            pc_c   = 1'b1;
            pc_sel = 2'b01;
          end
        end
      end
      S_MEM: begin
        req_c   = 1'b1;
        we_c    = is_sw;
        mem_src = 1'b1;
        if (mem_ack) next_state = is_sw ? S_FETCH : S_WB;
        else         next_state = S_MEM;
      end
      S_WB: begin
        reg_c = 1'b1;
        if (rtype)      reg_dst = 2'b01;
        else if (is_lw) wd_sel  = 2'b01;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so an in-flight access is abandoned immediately
  assign mem_req = reset & req_c;
  assign mem_we  = reset & we_c;
  assign ir_we   = reset & ir_c;
  assign pc_we   = reset & pc_c;
  assign reg_we  = reset & reg_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE && !supported) illegal <= 1'b1;
    end
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS core. It replaces single-cycle decode with a five-state FSM (FETCH/DECODE/EXEC/MEM/WB) that sequences the shared PC, IR, GPR file, ALU and a single unified memory port behind a request/acknowledge handshake. It sits between the IR opcode/funct fields and every write-enable and mux select in the datapath; the datapath itself stays unchanged apart from added select inputs.

## Interface

- No parameters; encodings are fixed below.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `op`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU result == 0
- `mem_ack`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  store (valid only with `mem_req`)
- `mem_src`  out  1  address select: 0 = PC, 1 = ALU result
- `ir_we`  out  1  load IR from memory read data
- `pc_we`  out  1  update PC
- `pc_sel`  out  2  00 PC+4, 01 branch target (PC + sext(imm)<<2), 10 {PC[31:28],imm26,00}, 11 GPR[rs]
- `reg_we`  out  1  GPR write
- `reg_dst`  out  2  00 rt, 01 rd, 10 $31
- `wd_sel`  out  2  00 ALU, 01 memory data, 10 PC (already PC+4)
- `alu_op`  out  2  00 add, 01 sub, 10 or, 11 lui (B<<16)
- `alu_bsel`  out  1  0 GPR[rt], 1 extended immediate
- `ext_op`  out  1  0 zero-extend, 1 sign-extend
- `state`  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB
- `illegal`  out  1  sticky: an unsupported instruction was decoded

## Operation

- Supported: addu (0/100001), subu (0/100011), jr (0/001000), nop (0/000000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011. Anything else is illegal.
- Outputs are combinational from `state`, `op`, `funct`, `zero` and `mem_ack`. Unlisted strobes are 0; unlisted selects are don't-care and are driven as 0.
- FETCH: `mem_req`=1, `mem_src`=0. On `mem_ack`: `ir_we`=1, `pc_we`=1, `pc_sel`=00, go to DECODE; otherwise hold.
- DECODE: j: `pc_we`, sel 10, go to FETCH. jal: same, plus `reg_we`, dst 10, wd 10. jr: `pc_we`, sel 11, go to FETCH. nop: go to FETCH. illegal: set `illegal`, go to FETCH (executed as nop). All others go to EXEC.
- EXEC: addu/subu: `alu_op` 00/01, bsel 0, go to WB. ori: op 10, bsel 1, ext 0, go to WB. lui: op 11, bsel 1, go to WB. lw/sw: op 00, bsel 1, ext 1, go to MEM. beq: op 01, bsel 0; if `zero`, `pc_we` with sel 01; go to FETCH.
- MEM: `mem_req`=1, `mem_src`=1, `mem_we`=(op==sw). Hold until `mem_ack`. sw then goes to FETCH; lw goes to WB. The datapath latches the ALU result in EXEC and read data on `mem_ack`.
- WB: `reg_we`=1. R-type: dst 01, wd 00. ori/lui: dst 00, wd 00. lw: dst 00, wd 01. Go to FETCH.
- `mem_ack` is ignored outside FETCH and MEM.
- `illegal` clears only on reset.

## Timing

- Reset (asynchronous assert): `state`=FETCH and `illegal`=0 immediately. While reset is 0, all strobes (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`) are forced to 0.
- First `mem_req` appears in the first cycle after reset deasserts.
- Latency with a zero-wait memory (`mem_ack` in the request cycle): j/jal/jr/nop/illegal 2 cycles; beq 3; addu/subu/ori/lui/sw 4; lw 5. Each memory wait cycle adds 1.
- `mem_req` stays high and its address select stays stable from assertion until the `mem_ack` cycle inclusive. `mem_req` drops in the next cycle.
- Reset asserted mid-MEM abandons the access and `mem_req` drops asynchronously. No PC or GPR write occurs for the aborted instruction.
- Exactly one `pc_we` per non-branch instruction (in FETCH). j/jal/jr and taken beq produce a second `pc_we`.

## Test plan

- Reset, then zero-wait memory with word 0x34080005 (ori $8,$0,5): states 0→1→2→4→0. `reg_we`=1 with dst 00 and wd 00 in cycle 4. `alu_op`=10, `ext_op`=0 in EXEC.
- lw 0x8C090000 with `mem_ack` delayed 3 cycles in MEM: MEM held for 4 cycles with `mem_src`=1 and `mem_we`=0. WB follows with wd 01. Total latency 8 cycles.
- beq 0x11000003 with `zero`=1, then with `zero`=0: `pc_we`=1 with sel 01 in EXEC only when `zero`=1. Both cases return to FETCH after 3 cycles.
- jal 0x0C000C00: DECODE asserts `pc_we` (sel 10) and `reg_we` (dst 10, wd 10) together, then FETCH.
- Word 0xFC000000: `illegal` rises after DECODE and no write strobes fire. Next fetch proceeds normally. `illegal` stays 1 until reset.
- sw 0xAC090004 with reset pulled low in the second MEM wait cycle: `mem_req` and `mem_we` drop in the same cycle, `state`=0. After release, FETCH restarts with `illegal`=0.
